// File: rtl/rv_loader_pkg.sv
// rv_loader_pkg: shared constants and types for the instruction byte loader.
package rv_loader_pkg;
    localparam int XLEN = 32;
    localparam int BYTE_W = 8;
    localparam logic [1:0] RV_LEN32_BITS = 2'b11;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    typedef logic [XLEN-1:0] instr_t;
endpackage

// File: rtl/instr_byte_assembler_if.sv
// instr_byte_assembler_if: byte stream in, assembled instruction handshake out.
interface instr_byte_assembler_if #(parameter int XLEN = 32);
    logic [7:0] byte_in;
    logic byte_valid;
    logic byte_ready;
    logic resync;
    logic [XLEN-1:0] instr_out;
    logic instr_valid;
    logic instr_ready;
    logic bad_encoding;
    modport master (
        output byte_in, byte_valid, resync, instr_ready,
        input byte_ready, instr_out, instr_valid, bad_encoding
    );
    modport slave (
        input byte_in, byte_valid, resync, instr_ready,
        output byte_ready, instr_out, instr_valid, bad_encoding
    );
endinterface

// File: rtl/valid_ready_reg.sv
// valid_ready_reg: one-entry valid/ready register; a load may coincide with a take.
module valid_ready_reg #(parameter int W = 32) (
    input logic clk,
    input logic rst,
    input logic load,
    input logic [W-1:0] load_data,
    input logic take,
    output logic free,
    output logic [W-1:0] data,
    output logic valid
);
    assign free = !valid || take;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data <= load_data;
            valid <= 1'b1;
        end else if (take) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_byte_assembler.sv
// instr_byte_assembler: packs little-endian bytes into words, with one held word
// behind the output register so collection continues under backpressure.
module instr_byte_assembler #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst,
    instr_byte_assembler_if.slave bus
);
    import rv_loader_pkg::*;
    localparam int BYTES = XLEN / BYTE_W;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
    logic [CW-1:0] byte_cnt, byte_idx;
    logic asm_full, accept, last, load, out_free, out_valid, bad;
    logic [XLEN-1:0] asm_data, asm_next, out_data;
    always_comb begin
        accept = bus.byte_valid && !asm_full;
        byte_idx = bus.resync ? '0 : byte_cnt;
        last = accept && !bus.resync && byte_cnt == LAST;
        asm_next = asm_data;
        for (int i = 0; i < BYTES; i++)
            if (accept && byte_idx == CW'(i)) asm_next[BYTE_W*i +: BYTE_W] = bus.byte_in;
        // asm_next equals the held word while full, since no byte is accepted then
        load = (asm_full || last) && out_free;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            asm_full <= 1'b0;
            asm_data <= '0;
            bad <= 1'b0;
        end else begin
            asm_data <= asm_next;
            byte_cnt <= accept ? (last ? '0 : byte_idx + 1'b1) : (bus.resync ? '0 : byte_cnt);
            asm_full <= asm_full ? !out_free : (last && !out_free);
            if (load && asm_next[1:0] != RV_LEN32_BITS) bad <= 1'b1;
        end
    end
    valid_ready_reg #(.W(XLEN)) out_stage (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_data(asm_next),
        .take(bus.instr_ready),
        .free(out_free),
        .data(out_data),
        .valid(out_valid)
    );
    assign bus.byte_ready = !asm_full;
    assign bus.instr_out = out_data;
    assign bus.instr_valid = out_valid;
    assign bus.bad_encoding = bad;
endmodule

// File: tb/tb_instr_byte_assembler.sv
// tb_instr_byte_assembler: directed checks of assembly, backpressure, resync,
// encoding flag, back-to-back words and asynchronous reset.
module tb_instr_byte_assembler;
    import rv_loader_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int n_pass = 0;
    int n_total = 0;
    always #5 clk = ~clk;
    instr_byte_assembler_if #(.XLEN(32)) bus ();
    instr_byte_assembler #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        instr_t w1, w2, w3;
        w1 = 32'h0000_0013;
        w2 = 32'h0010_8093;
        w3 = 32'h0020_8113;
        rst = 1'b1;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.resync = 1'b0;
        bus.instr_ready = 1'b0;
        #12;
        chk("rst_out", bus.instr_out, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_byte_ready", {31'b0, bus.byte_ready}, 32'h1);
        chk("rst_bad", {31'b0, bus.bad_encoding}, 32'h0);
        rst = 1'b0;
        // basic assembly
        bus.instr_ready = 1'b1;
        send(8'h93); send(8'h00); send(8'h10);
        chk("basic_not_yet", {31'b0, bus.instr_valid}, 32'h0);
        send(8'h00);
        chk("basic_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("basic_out", bus.instr_out, 32'h0010_0093);
        chk("basic_bad", {31'b0, bus.bad_encoding}, 32'h0);
        tick();
        chk("basic_one_cycle", {31'b0, bus.instr_valid}, 32'h0);
        // backpressure
        bus.instr_ready = 1'b0;
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        chk("bp_w1_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("bp_w1_out", bus.instr_out, w1);
        send(8'h93); send(8'h80); send(8'h10);
        chk("bp_ready_before8", {31'b0, bus.byte_ready}, 32'h1);
        send(8'h00);
        chk("bp_ready_low", {31'b0, bus.byte_ready}, 32'h0);
        chk("bp_full", {31'b0, dut.asm_full}, 32'h1);
        chk("bp_out_stable", bus.instr_out, w1);
        bus.byte_in = 8'h13;
        bus.byte_valid = 1'b1;
        tick(); tick();
        chk("bp_refused_cnt", {30'b0, dut.byte_cnt}, 32'h0);
        chk("bp_still_low", {31'b0, bus.byte_ready}, 32'h0);
        chk("bp_still_w1", bus.instr_out, w1);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("bp_w2_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("bp_w2_out", bus.instr_out, w2);
        chk("bp_ready_back", {31'b0, bus.byte_ready}, 32'h1);
        chk("bp_b9_not_taken", {30'b0, dut.byte_cnt}, 32'h0);
        tick();
        bus.byte_valid = 1'b0;
        chk("bp_b9_taken", {30'b0, dut.byte_cnt}, 32'h1);
        send(8'h81); send(8'h20); send(8'h00);
        chk("bp_w3_held", {31'b0, dut.asm_full}, 32'h1);
        chk("bp_w2_stable", bus.instr_out, w2);
        bus.instr_ready = 1'b1;
        tick();
        chk("bp_w3_out", bus.instr_out, w3);
        chk("bp_w3_valid", {31'b0, bus.instr_valid}, 32'h1);
        tick();
        chk("bp_drained", {31'b0, bus.instr_valid}, 32'h0);
        chk("bp_bad", {31'b0, bus.bad_encoding}, 32'h0);
        // resync, including together with what would be the 4th byte
        send(8'hAA); send(8'hBB); send(8'hCC);
        bus.resync = 1'b1;
        send(8'h13);
        bus.resync = 1'b0;
        chk("rs_no_word", {31'b0, bus.instr_valid}, 32'h0);
        chk("rs_cnt", {30'b0, dut.byte_cnt}, 32'h1);
        send(8'h00); send(8'h00); send(8'h00);
        chk("rs_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("rs_out", bus.instr_out, 32'h0000_0013);
        tick();
        // bad encoding is sticky through later legal words
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        chk("bad_delivered", {31'b0, bus.instr_valid}, 32'h1);
        chk("bad_out", bus.instr_out, 32'h0);
        chk("bad_set", {31'b0, bus.bad_encoding}, 32'h1);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        chk("bad_legal_out", bus.instr_out, 32'h0010_0093);
        chk("bad_sticky", {31'b0, bus.bad_encoding}, 32'h1);
        // back-to-back words four cycles apart
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        chk("b2b_w1", bus.instr_out, w1);
        chk("b2b_v1", {31'b0, bus.instr_valid}, 32'h1);
        send(8'h93);
        chk("b2b_gap", {31'b0, bus.instr_valid}, 32'h0);
        send(8'h80); send(8'h10); send(8'h00);
        chk("b2b_w2", bus.instr_out, w2);
        chk("b2b_v2", {31'b0, bus.instr_valid}, 32'h1);
        tick();
        chk("b2b_end", {31'b0, bus.instr_valid}, 32'h0);
        // asynchronous reset while a word is held
        bus.instr_ready = 1'b0;
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h80); send(8'h10); send(8'h00);
        chk("ar_held", {31'b0, dut.asm_full}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("ar_full", {31'b0, dut.asm_full}, 32'h0);
        chk("ar_cnt", {30'b0, dut.byte_cnt}, 32'h0);
        chk("ar_ready", {31'b0, bus.byte_ready}, 32'h1);
        chk("ar_bad", {31'b0, bus.bad_encoding}, 32'h0);
        chk("ar_out", bus.instr_out, 32'h0);
        #1 rst = 1'b0;
        bus.instr_ready = 1'b1;
        send(8'h13); send(8'h05); send(8'h00); send(8'h00);
        chk("ar_after_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("ar_after_out", bus.instr_out, 32'h0000_0513);
        chk("ar_after_bad", {31'b0, bus.bad_encoding}, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
